// File: rtl/xgcd_reset_sequencer.sv
// xgcd_reset_sequencer
// Staged reset-release controller for the XGCD block. It takes the already
// synchronized active-low reset and releases NUM_STAGES active-low stage
// resets one at a time, STAGE_DELAY cycles apart, bit 0 first. DONE goes high
// on the edge that releases the last stage.
//
// Optional feature macro: XGCD_RST_SEQ_SOFT_EN
//   defined   - a software request (SOFT_REQ/SOFT_ACK four-phase handshake)
//               re-asserts every stage reset, holds it for STAGE_DELAY edges
//               and then re-runs the release sequence.
//   undefined - SOFT_REQ is ignored, SOFT_ACK is tied low and the FSM only
//               has the SEQ and RUN states.
module xgcd_reset_sequencer #(
  parameter int NUM_STAGES  = 3,   // 1..8, bit 0 releases first
  parameter int STAGE_DELAY = 16   // >= 1, edges between releases / hold length
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  SOFT_REQ,
  output logic                  SOFT_ACK,
  output logic [NUM_STAGES-1:0] STAGE_RSTn,
  output logic                  DONE
);

  // A single-cycle delay or single stage still needs a 1-bit register.
  localparam int CNT_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

`ifdef XGCD_RST_SEQ_SOFT_EN
  typedef enum logic [1:0] {
    ST_SEQ       = 2'd0,
    ST_RUN       = 2'd1,
    ST_SOFT_HOLD = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_SEQ = 1'b0,
    ST_RUN = 1'b1
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    done_q, done_d;

`ifdef XGCD_RST_SEQ_SOFT_EN
  logic                    ack_q, ack_d;
  // Marks a release sequence that was started by a soft request, so only that
  // sequence raises the acknowledge when it completes.
  logic                    soft_seq_q, soft_seq_d;
`endif

  // Main state, counter, index and output registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_SEQ;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

`ifdef XGCD_RST_SEQ_SOFT_EN
  // Handshake registers for the soft reset request.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ack_q      <= 1'b0;
      soft_seq_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      soft_seq_q <= soft_seq_d;
    end
  end
`endif

  // Next-state logic: staged release, steady run and optional soft hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
`ifdef XGCD_RST_SEQ_SOFT_EN
    ack_d      = ack_q;
    soft_seq_d = soft_seq_q;
    // The acknowledge drops on the first edge that sees the request low,
    // whatever state the sequencer is in.
    if (ack_q && !SOFT_REQ) begin
      ack_d = 1'b0;
    end
`endif

    case (state_q)
      ST_SEQ: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Release exactly the stage addressed by the index; earlier bits
          // are already 1 and later bits stay 0, so order is preserved.
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == IDX_W'(k)) begin
              stage_d[k] = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            idx_d   = '0;
`ifdef XGCD_RST_SEQ_SOFT_EN
            if (soft_seq_q) begin
              ack_d      = 1'b1;
              soft_seq_d = 1'b0;
            end
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
`ifdef XGCD_RST_SEQ_SOFT_EN
        // A request is only taken while the previous one is fully closed
        // (acknowledge low), which enforces the four-phase protocol.
        if (SOFT_REQ && !ack_q) begin
          state_d    = ST_SOFT_HOLD;
          stage_d    = '0;
          done_d     = 1'b0;
          cnt_d      = '0;
          idx_d      = '0;
          soft_seq_d = 1'b1;
        end
`endif
      end

`ifdef XGCD_RST_SEQ_SOFT_EN
      ST_SOFT_HOLD: begin
        // Keep every stage in reset for STAGE_DELAY edges, then re-sequence.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SEQ;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      default: begin
        state_d = ST_SEQ;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign STAGE_RSTn = stage_q;
  assign DONE       = done_q;

`ifdef XGCD_RST_SEQ_SOFT_EN
  assign SOFT_ACK = ack_q;
`else
  assign SOFT_ACK = 1'b0;
  // Request input has no function in this build.
  logic unused_soft_req;
  assign unused_soft_req = SOFT_REQ;
`endif

endmodule

// File: tb/tb_xgcd_reset_sequencer.sv
// Testbench for xgcd_reset_sequencer. Two instances share clock, reset and
// request: A (3 stages, delay 4) and B (1 stage, delay 1). Expected outputs
// come from a reference model that derives each release edge from the time
// the current sequence started. Build with +define+XGCD_RST_SEQ_SOFT_EN to
// exercise the soft reset handshake.
module tb_xgcd_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_req;
  logic       ack_a, done_a, ack_b, done_b;
  logic [2:0] stg_a;
  logic [0:0] stg_b;

  int errors = 0;
  int checks = 0;

`ifdef XGCD_RST_SEQ_SOFT_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  xgcd_reset_sequencer #(.NUM_STAGES(3), .STAGE_DELAY(4)) u_dut_a (
    .CLK(clk), .RESETn(rst_n), .SOFT_REQ(soft_req),
    .SOFT_ACK(ack_a), .STAGE_RSTn(stg_a), .DONE(done_a)
  );

  xgcd_reset_sequencer #(.NUM_STAGES(1), .STAGE_DELAY(1)) u_dut_b (
    .CLK(clk), .RESETn(rst_n), .SOFT_REQ(soft_req),
    .SOFT_ACK(ack_b), .STAGE_RSTn(stg_b), .DONE(done_b)
  );

  // Reference model: index 0 = instance A, index 1 = instance B.
  int         m_n[2] = '{3, 1};
  int         m_d[2] = '{4, 1};
  logic [7:0] m_stage[2];
  bit         m_done[2];
  bit         m_ack[2];
  bit         m_pend[2];
  int         m_base[2];   // edge at which the current release countdown began
  int         m_e;         // edges since reset release

  task automatic model_reset();
    m_e = 0;
    for (int i = 0; i < 2; i++) begin
      m_stage[i] = '0;
      m_done[i]  = 1'b0;
      m_ack[i]   = 1'b0;
      m_pend[i]  = 1'b0;
      m_base[i]  = 0;
    end
  endtask

  // Stage k is out of reset once D*(k+1) edges have passed since the
  // countdown began; a soft request restarts the countdown D edges later.
  task automatic model_edge(input logic req);
    m_e++;
    for (int i = 0; i < 2; i++) begin
      bit new_done;
      if (SOFT_EN && m_done[i] && req && !m_ack[i]) begin
        m_base[i] = m_e + m_d[i];
        m_pend[i] = 1'b1;
      end else if (m_ack[i] && !req) begin
        m_ack[i] = 1'b0;
      end
      m_stage[i] = '0;
      for (int k = 0; k < m_n[i]; k++) begin
        m_stage[i][k] = (m_e >= m_base[i] + m_d[i] * (k + 1));
      end
      new_done = (m_e >= m_base[i] + m_d[i] * m_n[i]);
      if (m_pend[i] && new_done) begin
        m_ack[i]  = 1'b1;
        m_pend[i] = 1'b0;
      end
      m_done[i] = new_done;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(soft_req);
    #1;
  endtask

  // Asserts reset mid-cycle and releases it just after an edge, so the next
  // rising edge is edge 1.
  task automatic hold_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    soft_req = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (stg_a !== 3'b000 || done_a !== 1'b0 || ack_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: got stage=%b done=%b ack=%b want stage=000 done=0 ack=0",
               stg_a, done_a, ack_a);
    end
    checks++;
    if (stg_b !== 1'b0 || done_b !== 1'b0 || ack_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: got stage=%b done=%b ack=%b want stage=0 done=0 ack=0",
               stg_b, done_b, ack_b);
    end
    $display("test_reset: outputs held at reset values");
  endtask

  task automatic test_poweron();
    logic [2:0] plan_stage;
    hold_reset();
    for (int n = 0; n < 16; n++) begin
      tick();
      checks++;
      if (stg_a !== m_stage[0][2:0] || done_a !== m_done[0] || ack_a !== m_ack[0]) begin
        errors++;
        $display("FAIL poweron_a edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                 m_e, stg_a, done_a, ack_a, m_stage[0][2:0], m_done[0], m_ack[0]);
      end
      checks++;
      if (stg_b !== m_stage[1][0:0] || done_b !== m_done[1] || ack_b !== m_ack[1]) begin
        errors++;
        $display("FAIL poweron_b edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                 m_e, stg_b, done_b, ack_b, m_stage[1][0:0], m_done[1], m_ack[1]);
      end
      // Fixed release points for delay 4 / 3 stages.
      if (m_e == 3 || m_e == 4 || m_e == 7 || m_e == 8 || m_e == 11 || m_e == 12) begin
        plan_stage = (m_e >= 12) ? 3'b111 : (m_e >= 8) ? 3'b011 : (m_e >= 4) ? 3'b001 : 3'b000;
        checks++;
        if (stg_a !== plan_stage || done_a !== (m_e >= 12)) begin
          errors++;
          $display("FAIL poweron_plan edge %0d: got stage=%b done=%b want stage=%b done=%b",
                   m_e, stg_a, done_a, plan_stage, (m_e >= 12));
        end
      end
      if (m_e == 1) begin
        checks++;
        if (stg_b !== 1'b1 || done_b !== 1'b1) begin
          errors++;
          $display("FAIL single_stage edge 1: got stage=%b done=%b want stage=1 done=1",
                   stg_b, done_b);
        end
      end
    end
    $display("test_poweron: %0d edges sequenced", m_e);
  endtask

  task automatic test_async_reset();
    hold_reset();
    while (m_e < 6) tick();
    checks++;
    if (stg_a !== 3'b001) begin
      errors++;
      $display("FAIL midseq_pre edge 6: got stage=%b want stage=001", stg_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stg_a !== 3'b000 || done_a !== 1'b0 || stg_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL async_assert: got stage_a=%b done_a=%b stage_b=%b done_b=%b want all 0",
               stg_a, done_a, stg_b, done_b);
    end
    hold_reset();
    for (int n = 0; n < 14; n++) begin
      tick();
      checks++;
      if (stg_a !== m_stage[0][2:0] || done_a !== m_done[0] || ack_a !== m_ack[0]) begin
        errors++;
        $display("FAIL restart_a edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                 m_e, stg_a, done_a, ack_a, m_stage[0][2:0], m_done[0], m_ack[0]);
      end
      if (m_e == 4 || m_e == 8 || m_e == 12) begin
        checks++;
        if (stg_a !== ((m_e == 4) ? 3'b001 : (m_e == 8) ? 3'b011 : 3'b111)) begin
          errors++;
          $display("FAIL restart_plan edge %0d: got stage=%b", m_e, stg_a);
        end
      end
    end
    $display("test_async_reset: restart after mid-sequence reset checked");
  endtask

  task automatic test_soft_handshake();
    hold_reset();
    soft_req = 1'b0;
    while (m_e < 45) begin
      if (m_e == 19) soft_req = 1'b1;   // sampled high at edge 20
      if (m_e == 39) soft_req = 1'b0;   // sampled low at edge 40
      tick();
      checks++;
      if (stg_a !== m_stage[0][2:0] || done_a !== m_done[0] || ack_a !== m_ack[0]) begin
        errors++;
        $display("FAIL soft_a edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                 m_e, stg_a, done_a, ack_a, m_stage[0][2:0], m_done[0], m_ack[0]);
      end
      checks++;
      if (stg_b !== m_stage[1][0:0] || done_b !== m_done[1] || ack_b !== m_ack[1]) begin
        errors++;
        $display("FAIL soft_b edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                 m_e, stg_b, done_b, ack_b, m_stage[1][0:0], m_done[1], m_ack[1]);
      end
`ifdef XGCD_RST_SEQ_SOFT_EN
      if (m_e == 20 || m_e == 27 || m_e == 28 || m_e == 35 || m_e == 36 || m_e == 39 || m_e == 40) begin
        logic [2:0] ps;
        logic       pa;
        ps = (m_e >= 36) ? 3'b111 : (m_e >= 32) ? 3'b011 : (m_e >= 28) ? 3'b001 : 3'b000;
        pa = (m_e >= 36 && m_e < 40);
        checks++;
        if (stg_a !== ps || ack_a !== pa || done_a !== (m_e >= 36)) begin
          errors++;
          $display("FAIL soft_plan edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                   m_e, stg_a, done_a, ack_a, ps, (m_e >= 36), pa);
        end
      end
`else
      if (m_e >= 20) begin
        checks++;
        if (stg_a !== 3'b111 || ack_a !== 1'b0) begin
          errors++;
          $display("FAIL soft_disabled edge %0d: got stage=%b ack=%b want stage=111 ack=0",
                   m_e, stg_a, ack_a);
        end
      end
`endif
    end
    $display("test_soft_handshake: request at edge 20, drop at edge 40 (soft_en=%0d)", SOFT_EN);
  endtask

  // A request held through power-up is first seen once the sequencer is in
  // RUN, i.e. one edge after DONE rises.
  task automatic test_req_during_poweron();
    hold_reset();
    soft_req = 1'b1;
    for (int n = 0; n < 44; n++) begin
      if (n == 40) soft_req = 1'b0;
      tick();
      checks++;
      if (stg_a !== m_stage[0][2:0] || done_a !== m_done[0] || ack_a !== m_ack[0]) begin
        errors++;
        $display("FAIL early_req_a edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                 m_e, stg_a, done_a, ack_a, m_stage[0][2:0], m_done[0], m_ack[0]);
      end
      checks++;
      if (stg_b !== m_stage[1][0:0] || done_b !== m_done[1] || ack_b !== m_ack[1]) begin
        errors++;
        $display("FAIL early_req_b edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                 m_e, stg_b, done_b, ack_b, m_stage[1][0:0], m_done[1], m_ack[1]);
      end
    end
    soft_req = 1'b0;
    $display("test_req_during_poweron: request held through power-up");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int len;
      soft_req = 1'(($urandom_range(0, 1)));
      hold_reset();
      len = $urandom_range(20, 90);
      for (int n = 0; n < len; n++) begin
        if ($urandom_range(0, 5) == 0) soft_req = ~soft_req;
        tick();
        checks++;
        if (stg_a !== m_stage[0][2:0] || done_a !== m_done[0] || ack_a !== m_ack[0]) begin
          errors++;
          $display("FAIL random_a round %0d edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                   r, m_e, stg_a, done_a, ack_a, m_stage[0][2:0], m_done[0], m_ack[0]);
        end
        checks++;
        if (stg_b !== m_stage[1][0:0] || done_b !== m_done[1] || ack_b !== m_ack[1]) begin
          errors++;
          $display("FAIL random_b round %0d edge %0d: got stage=%b done=%b ack=%b want stage=%b done=%b ack=%b",
                   r, m_e, stg_b, done_b, ack_b, m_stage[1][0:0], m_done[1], m_ack[1]);
        end
      end
      // Abort the run with an asynchronous reset at a random point.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (stg_a !== 3'b000 || done_a !== 1'b0 || ack_a !== 1'b0 || stg_b !== 1'b0 || ack_b !== 1'b0) begin
        errors++;
        $display("FAIL random_abort round %0d: got stage_a=%b done_a=%b ack_a=%b stage_b=%b ack_b=%b want all 0",
                 r, stg_a, done_a, ack_a, stg_b, ack_b);
      end
      $display("test_random: round %0d ran %0d edges", r, len);
    end
    soft_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_poweron();
    test_async_reset();
    test_soft_handshake();
    test_req_during_poweron();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
